dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU data port requests an access this cycle.
REQ-006 cpu_we  input  1  CPU access is a write (1) or a read (0).
REQ-007 cpu_addr  input  AW  CPU byte address.
REQ-008 cpu_wdata  input  DW  CPU write data.
REQ-009 cpu_gnt  output  1  CPU access is issued to memory this cycle.
REQ-010 cpu_rvalid  output  1  rdata holds the CPU read result.
REQ-011 ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid: same widths and meanings for the external (loader/debug) port.
REQ-012 ext_lock  input  1  external port holds ownership across consecutive accesses.
REQ-013 rdata  output  DW  read data shared by both ports, qualified by *_rvalid.
REQ-014 mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-015 mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW, valid exactly one cycle after a read strobe.

Function
REQ-016 At most one access SHALL be issued per cycle; cpu_gnt and ext_gnt SHALL never be high together.
REQ-017 Grants SHALL be combinational from requests and registered state; a request is served in the same cycle its gnt is high.
REQ-018 mem_en SHALL equal cpu_gnt OR ext_gnt; mem_we, mem_addr, mem_wdata SHALL mux from the granted port; they SHALL be 0 when no grant.
REQ-019 FSM states: IDLE, LOCKED.
REQ-020 IDLE, single requester: that requester is granted.
REQ-021 IDLE, both requesting: round-robin; the port not granted most recently wins; last-grant register updates on every grant.
REQ-022 IDLE -> LOCKED when ext_gnt and ext_lock are both high in that cycle.
REQ-023 LOCKED: only ext may be granted (when ext_req high); cpu_gnt SHALL stay 0.
REQ-024 LOCKED -> IDLE at the first clock edge where ext_lock is low; cpu may be granted in that same cycle if ext_req is also low.
REQ-025 ext_lock while ext is not granted in IDLE SHALL have no effect.
REQ-026 A granted read SHALL set a one-deep pending register (valid, owner); next cycle the owner's rvalid SHALL be 1 and rdata = mem_rdata; otherwise rdata = 0.
REQ-027 Back-to-back reads, including alternating owners, SHALL sustain one access per cycle with each rvalid routed to the correct owner.
REQ-028 Writes SHALL never raise rvalid.

Reset
REQ-029 Reset SHALL force: state IDLE, last-grant = ext (CPU wins first tie), pending read cleared.
REQ-030 During reset all gnt, rvalid, mem_en, mem_we outputs SHALL be 0 and rdata, mem_addr, mem_wdata SHALL be 0.
REQ-031 Reset asserted with a read pending SHALL drop that read; no rvalid after reset release.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding and the owner encoding (OWN_CPU = 0, OWN_EXT = 1).
REQ-033 One sub-module, rr_arb2 (2-input round-robin picker with last-grant state), is natural; the rest is inline.
REQ-034 Target 120-400 lines of RTL; no memory instance inside the block.

Verification
REQ-035 Reset release, cpu_req=1 ext_req=1 both reads -> cycle 0 cpu_gnt, cycle 1 ext_gnt plus cpu_rvalid with rdata=mem word at cpu_addr.
REQ-036 Both ports request continuously for 8 cycles -> grants alternate CPU/EXT, 4 each, never overlapping.
REQ-037 ext write 0xDEADBEEF to 0x40 with ext_lock=1 for 3 cycles while cpu_req=1 -> cpu_gnt=0 for those 3 cycles; cpu granted in the cycle after ext_lock falls.
REQ-038 CPU read of 0x40 after REQ-037 -> cpu_rvalid one cycle later, rdata=0xDEADBEEF, ext_rvalid=0.
REQ-039 rst asserted the cycle after a granted read -> no rvalid on either port; all outputs 0 immediately (asynchronous).
REQ-040 Writes only for 5 cycles on both ports -> cpu_rvalid and ext_rvalid stay 0 throughout.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dram_arbiter_pkg
// Shared type definitions for the DRAM arbiter slice.
//   arb_state_t : arbitration FSM state (IDLE / LOCKED)
//   owner_t     : which port owns an access (OWN_CPU = 0, OWN_EXT = 1)
//   RESET_LAST_OWNER : last-grant value after reset, so the CPU wins the
//                      first tie.
// ---------------------------------------------------------------------------
package dram_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    localparam owner_t RESET_LAST_OWNER = OWN_EXT;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker with its own last-grant register.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_cpu, req_ext  : already-qualified requests (masking done by caller)
//   gnt_cpu, gnt_ext  : one-hot (or zero) combinational grants
// A lone requester always wins; on a tie the port that was not granted
// most recently wins. The last-grant register follows every grant.
// ---------------------------------------------------------------------------
module rr_arb2
    import dram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_cpu,
    input  logic req_ext,
    output logic gnt_cpu,
    output logic gnt_ext
);

    owner_t last_q;

    // Tie-break looks at who was served last; single requests pass through.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_ext = 1'b0;
        if (req_cpu && req_ext) begin
            if (last_q == OWN_EXT) begin
                gnt_cpu = 1'b1;
            end else begin
                gnt_ext = 1'b1;
            end
        end else begin
            gnt_cpu = req_cpu;
            gnt_ext = req_ext;
        end
    end

    // Remember the most recent winner; reset points at EXT so CPU wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= RESET_LAST_OWNER;
        end else if (gnt_cpu) begin
            last_q <= OWN_CPU;
        end else if (gnt_ext) begin
            last_q <= OWN_EXT;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
// Arbitrates a CPU data port and an external (loader/debug) port onto one
// single-ported memory, one access per cycle, with an optional lock that
// lets the external port keep ownership across consecutive accesses.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   cpu_req/we/addr/wdata, cpu_gnt   : CPU request and same-cycle grant
//   cpu_rvalid                       : rdata carries the CPU read result
//   ext_req/we/addr/wdata, ext_gnt   : external request and grant
//   ext_lock                         : external port holds ownership
//   ext_rvalid                       : rdata carries the external read result
//   rdata                            : shared read data (0 when not valid)
//   mem_en/we/addr/wdata, mem_rdata  : memory side; read data returns one
//                                      cycle after the read strobe
// ---------------------------------------------------------------------------
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    input  logic          ext_lock,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       cpu_eligible;
    logic       ext_eligible;
    logic       pend_valid;
    owner_t     pend_owner;
    logic       read_issue;

    // While locked the CPU is only eligible once the lock has dropped and
    // the external port is idle. Requests are masked during reset so every
    // grant and memory strobe is 0 immediately on assertion.
    always_comb begin
        ext_eligible = ext_req && !rst;
        cpu_eligible = cpu_req && !rst;
        if (state_q == ST_LOCKED) begin
            cpu_eligible = cpu_eligible && !ext_lock && !ext_req;
        end
    end

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_cpu (cpu_eligible),
        .req_ext (ext_eligible),
        .gnt_cpu (cpu_gnt),
        .gnt_ext (ext_gnt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock is only taken when the external port actually wins while asking
    // for it; it is released at the first edge where ext_lock is low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ext_gnt && ext_lock) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!ext_lock) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side mux from the granted port; all zero when nobody is granted.
    always_comb begin
        mem_en    = cpu_gnt || ext_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    assign read_issue = mem_en && !mem_we;

    // One-deep pending-read tracker: a read issued this cycle returns next
    // cycle, so a new read can be tracked every cycle without a queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_owner <= OWN_CPU;
        end else begin
            pend_valid <= read_issue;
            if (read_issue) begin
                pend_owner <= ext_gnt ? OWN_EXT : OWN_CPU;
            end
        end
    end

    assign cpu_rvalid = pend_valid && (pend_owner == OWN_CPU);
    assign ext_rvalid = pend_valid && (pend_owner == OWN_EXT);
    assign rdata      = pend_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_arbiter
// Self-checking bench for dram_arbiter: a behavioural memory feeds the DUT,
// and a rule-level reference model predicts grants, memory strobes and read
// returns every cycle. Directed scenarios cover reset, tie-breaking, the
// external lock and asynchronous reset with a pending read; a randomized
// phase follows.
// ---------------------------------------------------------------------------
module tb_dram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_lock;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks;
    int failures;

    // Behavioural memory driven by the DUT, and the model's own copy.
    logic [DW-1:0] mem_array [256];
    logic [DW-1:0] ref_mem   [256];

    // Reference model: locked flag, who was served last, pending read.
    bit            m_locked;
    bit            m_last_ext;
    bit            m_pend_valid;
    bit            m_pend_ext;
    logic [DW-1:0] m_pend_data;

    // Values observed in the most recent cycle, for directed checks.
    logic          obs_cpu_gnt;
    logic          obs_ext_gnt;
    logic          obs_cpu_rvalid;
    logic          obs_ext_rvalid;
    logic [DW-1:0] obs_rdata;
    int            cpu_gnt_cnt;
    int            ext_gnt_cnt;
    int            overlap_cnt;
    int            rvalid_cnt;

    dram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_lock   (ext_lock),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_array[mem_addr[9:2]] <= mem_wdata;
            end else begin
                mem_rdata <= mem_array[mem_addr[9:2]];
            end
        end
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'(i) * 32'h0001_0203) ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_locked     = 1'b0;
        m_last_ext   = 1'b1;
        m_pend_valid = 1'b0;
        m_pend_ext   = 1'b0;
        m_pend_data  = '0;
    endtask

    // Drive one cycle of requests, check every output against the model
    // mid-cycle, then advance the model at the clock edge.
    task automatic applyStimulus(input logic cr, input logic cwe,
                                 input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                                 input logic er, input logic ewe,
                                 input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
                                 input logic el);
        logic          exp_cg;
        logic          exp_eg;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        cpu_req   = cr;
        cpu_we    = cwe;
        cpu_addr  = ca;
        cpu_wdata = cwd;
        ext_req   = er;
        ext_we    = ewe;
        ext_addr  = ea;
        ext_wdata = ewd;
        ext_lock  = el;
        @(negedge clk);
        if (m_locked) begin
            exp_eg = er;
            exp_cg = cr && !el && !er;
        end else if (cr && er) begin
            exp_cg = m_last_ext;
            exp_eg = !m_last_ext;
        end else begin
            exp_cg = cr;
            exp_eg = er;
        end
        exp_we    = exp_cg ? cwe : (exp_eg ? ewe : 1'b0);
        exp_addr  = exp_cg ? ca  : (exp_eg ? ea  : '0);
        exp_wdata = exp_cg ? cwd : (exp_eg ? ewd : '0);

        obs_cpu_gnt    = cpu_gnt;
        obs_ext_gnt    = ext_gnt;
        obs_cpu_rvalid = cpu_rvalid;
        obs_ext_rvalid = ext_rvalid;
        obs_rdata      = rdata;
        if (cpu_gnt) cpu_gnt_cnt++;
        if (ext_gnt) ext_gnt_cnt++;
        if (cpu_gnt && ext_gnt) overlap_cnt++;
        if (cpu_rvalid || ext_rvalid) rvalid_cnt++;

        checkOutput("cpu_gnt",    cpu_gnt,    exp_cg);
        checkOutput("ext_gnt",    ext_gnt,    exp_eg);
        checkOutput("mem_en",     mem_en,     exp_cg || exp_eg);
        checkOutput("mem_we",     mem_we,     exp_we);
        checkOutput("mem_addr",   mem_addr,   exp_addr);
        checkOutput("mem_wdata",  mem_wdata,  exp_wdata);
        checkOutput("cpu_rvalid", cpu_rvalid, m_pend_valid && !m_pend_ext);
        checkOutput("ext_rvalid", ext_rvalid, m_pend_valid && m_pend_ext);
        checkOutput("rdata",      rdata,      m_pend_valid ? m_pend_data : '0);

        @(posedge clk);
        m_pend_valid = (exp_cg || exp_eg) && !exp_we;
        m_pend_ext   = exp_eg;
        if (m_pend_valid) m_pend_data = ref_mem[exp_addr[9:2]];
        if ((exp_cg || exp_eg) && exp_we) ref_mem[exp_addr[9:2]] = exp_wdata;
        if (exp_cg || exp_eg) m_last_ext = exp_eg;
        m_locked = m_locked ? el : (exp_eg && el);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_cpu_gnt"},    cpu_gnt,    0);
        checkOutput({tag, "_ext_gnt"},    ext_gnt,    0);
        checkOutput({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
        checkOutput({tag, "_ext_rvalid"}, ext_rvalid, 0);
        checkOutput({tag, "_rdata"},      rdata,      0);
        checkOutput({tag, "_mem_en"},     mem_en,     0);
        checkOutput({tag, "_mem_we"},     mem_we,     0);
        checkOutput({tag, "_mem_addr"},   mem_addr,   0);
        checkOutput({tag, "_mem_wdata"},  mem_wdata,  0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = init_word(i);
            ref_mem[i]   = init_word(i);
        end
        mem_rdata = '0;

        // Reset held with both ports requesting: everything must stay 0.
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h1111_2222;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h200; ext_wdata = 32'h3333_4444;
        ext_lock = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();

        $display("[TB] first tie after reset");
        applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 0);
        checkOutput("t0_cpu_first", obs_cpu_gnt, 1);
        applyStimulus(1, 0, 32'h14, 0, 1, 0, 32'h20, 0, 0);
        checkOutput("t1_ext_gnt",    obs_ext_gnt,    1);
        checkOutput("t1_cpu_rvalid", obs_cpu_rvalid, 1);
        checkOutput("t1_rdata",      obs_rdata,      init_word(4));

        $display("[TB] continuous contention");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cpu_gnt_cnt = 0; ext_gnt_cnt = 0; overlap_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 32'(i * 4), 0, 1, 0, 32'(i * 4 + 64), 0, 0);
        end
        checkOutput("rr_cpu_count", cpu_gnt_cnt, 4);
        checkOutput("rr_ext_count", ext_gnt_cnt, 4);
        checkOutput("rr_overlap",   overlap_cnt, 0);

        $display("[TB] external lock");
        applyStimulus(1, 1, 32'h80, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 32'h40, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 1);
            checkOutput("lock_cpu_blocked", obs_cpu_gnt, 0);
            checkOutput("lock_ext_served",  obs_ext_gnt, 1);
        end
        applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        checkOutput("unlock_cpu_gnt", obs_cpu_gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lock_rd_rvalid", obs_cpu_rvalid, 1);
        checkOutput("lock_rd_rdata",  obs_rdata,      32'hDEAD_BEEF);
        checkOutput("lock_rd_ext_rv", obs_ext_rvalid, 0);

        $display("[TB] reset with a pending read");
        applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        cpu_req = 1'b1; ext_req = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_cpu_rv", obs_cpu_rvalid, 0);
        checkOutput("post_rst_ext_rv", obs_ext_rvalid, 0);

        $display("[TB] write-only traffic");
        rvalid_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 32'($urandom_range(0, 255)) << 2, $urandom,
                          1, 1, 32'($urandom_range(0, 255)) << 2, $urandom, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("writes_no_rvalid", rvalid_cnt, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 255)) << 2, $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 255)) << 2, $urandom,
                          1'($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
